// File: rtl/core_net_hub.sv
// Packet hub for the cores of one tile: per-source FIFOs, one-hot destination routing
// with per-output round-robin arbitration, plus barrier/exception status reduction.
module core_net_hub #(
  parameter int unsigned num_ch_p       = 4,
  parameter int unsigned packet_width_p = 48,
  parameter int unsigned fifo_depth_p   = 4,
  parameter int unsigned mask_length_p  = 10,
  parameter int unsigned cnt_width_p    = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [num_ch_p*packet_width_p-1:0]  net_packet_flat_i,
  output logic [num_ch_p-1:0]                 net_ready_o,
  output logic [num_ch_p*packet_width_p-1:0]  net_packet_flat_o,
  input  logic [num_ch_p-1:0]                 net_ready_i,
  input  logic [num_ch_p*mask_length_p-1:0]   barrier_flat_i,
  input  logic [num_ch_p-1:0]                 exception_i,
  output logic [mask_length_p-1:0]            barrier_o,
  output logic                                exception_o,
  output logic [num_ch_p-1:0]                 exception_src_o,
  output logic                                route_err_o,
  output logic [cnt_width_p-1:0]              drop_count_o
);

  localparam int unsigned W  = packet_width_p;
  localparam int unsigned AW = $clog2(fifo_depth_p);
  localparam int unsigned PW = $clog2(num_ch_p);
  localparam int unsigned DL = W - 1 - num_ch_p;  // LSB of the destination field
  localparam logic [AW:0]            PTR_ONE = 1;
  localparam logic [cnt_width_p-1:0] CNT_ONE = 1;

  typedef logic [W-1:0] pkt_t;

  pkt_t                     mem_q   [num_ch_p][fifo_depth_p];
  pkt_t                     mem_d   [num_ch_p][fifo_depth_p];
  logic [AW:0]              wptr_q  [num_ch_p];
  logic [AW:0]              wptr_d  [num_ch_p];
  logic [AW:0]              rptr_q  [num_ch_p];
  logic [AW:0]              rptr_d  [num_ch_p];
  pkt_t                     out_q   [num_ch_p];
  pkt_t                     out_d   [num_ch_p];
  logic [PW-1:0]            rr_q    [num_ch_p];
  logic [PW-1:0]            rr_d    [num_ch_p];
  logic [mask_length_p-1:0] barrier_q, barrier_d;
  logic [num_ch_p-1:0]      exc_q, exc_d;
  logic                     route_err_q, route_err_d;
  logic [cnt_width_p-1:0]   drop_q, drop_d;

  logic [num_ch_p-1:0] full, empty, pop;
  pkt_t                head   [num_ch_p];
  pkt_t                in_pkt [num_ch_p];
  logic                found;
  logic [PW-1:0]       idx;

  always_comb begin
    for (int unsigned c = 0; c < num_ch_p; c++) begin
      full[c]   = (wptr_q[c][AW] != rptr_q[c][AW]) &&
                  (wptr_q[c][AW-1:0] == rptr_q[c][AW-1:0]);
      empty[c]  = (wptr_q[c] == rptr_q[c]);
      head[c]   = mem_q[c][rptr_q[c][AW-1:0]];
      in_pkt[c] = net_packet_flat_i[c*W +: W];
    end
  end

  always_comb begin
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    out_d       = out_q;
    rr_d        = rr_q;
    route_err_d = route_err_q;
    drop_d      = drop_q;
    pop         = '0;
    found       = 1'b0;
    idx         = '0;
    exc_d       = exc_q | exception_i;
    barrier_d   = '1;
    for (int unsigned c = 0; c < num_ch_p; c++) begin
      barrier_d = barrier_d & barrier_flat_i[c*mask_length_p +: mask_length_p];
    end

    // Accept: ready depends only on registered full, so an illegal packet is still taken.
    for (int unsigned c = 0; c < num_ch_p; c++) begin
      if (in_pkt[c][W-1] && !full[c]) begin
        if ($onehot(in_pkt[c][W-2 -: num_ch_p])) begin
          mem_d[c][wptr_q[c][AW-1:0]] = in_pkt[c];
          wptr_d[c] = wptr_q[c] + PTR_ONE;
        end else begin
          route_err_d = 1'b1;
          if (drop_d != '1) drop_d = drop_d + CNT_ONE;
        end
      end
    end

    // Each head carries a single destination bit, so grants never collide across outputs.
    for (int unsigned d = 0; d < num_ch_p; d++) begin
      if (!out_q[d][W-1] || net_ready_i[d]) begin
        found    = 1'b0;
        out_d[d] = '0;
        for (int unsigned k = 0; k < num_ch_p; k++) begin
          idx = PW'((32'(rr_q[d]) + k) % num_ch_p);
          if (!found && !empty[idx] && head[idx][DL + d]) begin
            found    = 1'b1;
            out_d[d] = head[idx];
            pop[idx] = 1'b1;
            rr_d[d]  = PW'((32'(idx) + 1) % num_ch_p);
          end
        end
      end
    end

    for (int unsigned c = 0; c < num_ch_p; c++) begin
      if (pop[c]) rptr_d[c] = rptr_q[c] + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q       <= '{default: '0};
      wptr_q      <= '{default: '0};
      rptr_q      <= '{default: '0};
      out_q       <= '{default: '0};
      rr_q        <= '{default: '0};
      barrier_q   <= '0;
      exc_q       <= '0;
      route_err_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      out_q       <= out_d;
      rr_q        <= rr_d;
      barrier_q   <= barrier_d;
      exc_q       <= exc_d;
      route_err_q <= route_err_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    net_ready_o = ~full;
    for (int unsigned d = 0; d < num_ch_p; d++) begin
      net_packet_flat_o[d*W +: W] = out_q[d];
    end
  end

  assign barrier_o       = barrier_q;
  assign exception_src_o = exc_q;
  assign exception_o     = |exc_q;
  assign route_err_o     = route_err_q;
  assign drop_count_o    = drop_q;

endmodule

// File: tb/tb_core_net_hub.sv
// Directed bench for core_net_hub: per-output expected queues filled on accept,
// drained and compared whenever an output is consumed.
module tb_core_net_hub;
  localparam int N  = 4;
  localparam int W  = 48;
  localparam int M  = 10;
  localparam int CW = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] pin;
  logic [N-1:0]   rdy_o;
  logic [N*W-1:0] pout;
  logic [N-1:0]   rdy_i;
  logic [N*M-1:0] bar_i;
  logic [N-1:0]   exc_i;
  logic [M-1:0]   bar_o;
  logic           exc_o;
  logic [N-1:0]   exc_src;
  logic           rerr;
  logic [CW-1:0]  drops;

  int unsigned total = 0, passed = 0, failed = 0;
  logic [W-1:0] exp_q [N][$];
  int           delivered [N];
  logic [N-1:0] acc_last;
  int           seq [N];

  core_net_hub #(
    .num_ch_p(N), .packet_width_p(W), .fifo_depth_p(4),
    .mask_length_p(M), .cnt_width_p(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .net_packet_flat_i(pin), .net_ready_o(rdy_o),
    .net_packet_flat_o(pout), .net_ready_i(rdy_i),
    .barrier_flat_i(bar_i), .exception_i(exc_i),
    .barrier_o(bar_o), .exception_o(exc_o), .exception_src_o(exc_src),
    .route_err_o(rerr), .drop_count_o(drops)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk_raw(input logic [N-1:0] dst, input logic [42:0] pl);
    return {1'b1, dst, pl};
  endfunction

  function automatic logic [W-1:0] mk(input logic [N-1:0] dst, input int src, input int s);
    return mk_raw(dst, {19'd0, 8'(src), 16'(s)});
  endfunction

  task automatic set_in(input int c, input logic [W-1:0] p);
    pin[c*W +: W] = p;
  endtask

  task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called away from the clock edge: anything valid with ready high is consumed at the next edge.
  task automatic tick();
    logic [W-1:0] o;
    for (int d = 0; d < N; d++) begin
      o = pout[d*W +: W];
      if (o[W-1] && rdy_i[d]) begin
        if (exp_q[d].size() == 0) check($sformatf("unexpected_out%0d", d), o, '0);
        else begin
          check($sformatf("deliver_out%0d_n%0d", d, delivered[d]), o, exp_q[d].pop_front());
          delivered[d]++;
        end
      end
    end
    for (int c = 0; c < N; c++) acc_last[c] = pin[c*W + W - 1] && rdy_o[c];
    @(posedge clk);
    #1;
  endtask

  initial begin
    int i;
    int srcs [3];
    srcs = '{0, 1, 3};
    reset = 1'b1;
    pin   = '0;
    rdy_i = '1;
    bar_i = '0;
    exc_i = '0;
    delivered = '{default: 0};
    seq = '{default: 0};
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_pkt_o", pout, '0);
    check("rst_ready_o", rdy_o, 4'hF);
    check("rst_barrier", bar_o, '0);
    check("rst_exc", exc_o, 1'b0);
    check("rst_exc_src", exc_src, '0);
    check("rst_route_err", rerr, 1'b0);
    check("rst_drops", drops, '0);
    reset = 1'b0;
    tick();
    check("idle_pkt_o", pout, '0);

    // Single packet ch0 -> ch2, two-cycle latency
    set_in(0, mk_raw(4'b0100, 43'h00ABCDEF));
    exp_q[2].push_back(mk_raw(4'b0100, 43'h00ABCDEF));
    tick();
    set_in(0, '0);
    check("single_acc", acc_last[0], 1'b1);
    check("single_1cyc", pout, '0);
    tick();
    check("single_2cyc", pout, {mk_raw(4'b0100, 43'h00ABCDEF), 96'd0});
    tick();
    check("single_drained", exp_q[2].size(), 0);

    // Illegal destinations
    set_in(1, mk(4'b0000, 1, 7));
    tick();
    check("illegal0_ready", rdy_o, 4'hF);
    check("illegal0_drops", drops, 1);
    set_in(1, mk(4'b0110, 1, 8));
    tick();
    set_in(1, '0);
    check("illegal1_ready", rdy_o, 4'hF);
    repeat (3) tick();
    check("illegal_route_err", rerr, 1'b1);
    check("illegal_drops", drops, 2);
    check("illegal_no_out", pout, '0);

    // Barrier reduction and sticky exceptions
    bar_i = {10'h1F0, 10'h3FF, 10'h3F0, 10'h3FF};
    check("barrier_pre", bar_o, '0);
    tick();
    check("barrier_and", bar_o, 10'h1F0);
    exc_i = 4'b0100;
    check("exc_pre", exc_o, 1'b0);
    tick();
    exc_i = '0;
    check("exc_set", exc_o, 1'b1);
    check("exc_src_set", exc_src, 4'b0100);
    repeat (3) tick();
    check("exc_src_held", exc_src, 4'b0100);
    bar_i = '0;

    // Backpressure on output 1 while ch2 streams six packets
    delivered = '{default: 0};
    rdy_i = 4'b1101;
    i = 0;
    set_in(2, mk(4'b0010, 2, 0));
    for (int t = 0; t < 10; t++) begin
      tick();
      if (acc_last[2]) begin
        exp_q[1].push_back(mk(4'b0010, 2, i));
        i++;
        set_in(2, (i < 6) ? mk(4'b0010, 2, i) : '0);
      end
      if (t == 3) check("bp_hold_early", pout[W +: W], mk(4'b0010, 2, 0));
    end
    check("bp_accepted", i, 5);
    check("bp_ready", rdy_o, 4'b1011);
    check("bp_hold_late", pout[W +: W], mk(4'b0010, 2, 0));
    rdy_i = '1;
    for (int b = 0; b < 40 && delivered[1] < 6; b++) begin
      tick();
      if (acc_last[2]) begin
        exp_q[1].push_back(mk(4'b0010, 2, i));
        i++;
        set_in(2, (i < 6) ? mk(4'b0010, 2, i) : '0);
      end
    end
    check("bp_delivered", delivered[1], 6);
    check("bp_ready_back", rdy_o, 4'hF);

    // Contention: ch0, ch1, ch3 all to output 0, round-robin 0,1,3
    delivered = '{default: 0};
    for (int k = 0; k < 30; k++) exp_q[0].push_back(mk(4'b0001, srcs[k % 3], k / 3));
    foreach (srcs[j]) set_in(srcs[j], mk(4'b0001, srcs[j], 0));
    for (int b = 0; b < 200 && delivered[0] < 30; b++) begin
      tick();
      foreach (srcs[j]) begin
        if (acc_last[srcs[j]]) begin
          seq[srcs[j]]++;
          set_in(srcs[j], mk(4'b0001, srcs[j], seq[srcs[j]]));
        end
      end
    end
    check("rr_delivered", delivered[0], 30);

    // Reset with packets still queued
    pin   = '0;
    rdy_i = '0;
    reset = 1'b1;
    #1;
    check("midrst_pkt_o", pout, '0);
    check("midrst_ready", rdy_o, 4'hF);
    check("midrst_exc", exc_o, 1'b0);
    check("midrst_exc_src", exc_src, '0);
    check("midrst_route_err", rerr, 1'b0);
    check("midrst_drops", drops, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rdy_i = '1;
    repeat (8) tick();
    check("postrst_no_out", pout, '0);

    for (int d = 0; d < N; d++) check($sformatf("queue%0d_empty", d), exp_q[d].size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/core_net_hub.md
Name: core_net_hub

Overview:
- Parametrised packet hub connecting num_ch_p flattened core network ports. Each channel carries one flattened net packet in and one out.
- Each source has its own FIFO. Packets are routed by a one-hot destination field, with per-output round-robin arbitration and ready/valid backpressure on both sides.
- The hub also reduces per-core barrier masks and exception flags into tile-level status.
- Sits between the core_flattened instances of a multi-core tile and the tile boundary.

Parameters:
- num_ch_p, 4, number of core channels (2..8).
- packet_width_p, 48, flattened packet width. Bit [packet_width_p-1] is valid. Bits [packet_width_p-2 -: num_ch_p] are the one-hot destination. Remaining bits are payload.
- fifo_depth_p, 4, per-source FIFO depth; power of 2, at least 2.
- mask_length_p, 10, barrier mask width per channel.
- cnt_width_p, 16, drop counter width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- net_packet_flat_i  input  num_ch_p*packet_width_p  source packets; channel c occupies slice [c*packet_width_p +: packet_width_p]
- net_ready_o  output  num_ch_p  source FIFO c can accept a packet
- net_packet_flat_o  output  num_ch_p*packet_width_p  delivered packets, same slicing
- net_ready_i  input  num_ch_p  destination c consumes its output this cycle
- barrier_flat_i  input  num_ch_p*mask_length_p  per-core barrier masks
- exception_i  input  num_ch_p  per-core exception flags
- barrier_o  output  mask_length_p  registered bitwise AND of all barrier masks
- exception_o  output  1  sticky OR of exception_i
- exception_src_o  output  num_ch_p  sticky per-channel exception record
- route_err_o  output  1  sticky flag: an illegal destination was seen
- drop_count_o  output  cnt_width_p  count of dropped packets, saturating

Behaviour:
- Reset (async assert, synchronous-edge release):
  - All FIFOs empty; net_ready_o = all ones.
  - All output registers invalid, net_packet_flat_o = 0.
  - barrier_o = 0; exception_o = 0; exception_src_o = 0; route_err_o = 0; drop_count_o = 0.
  - All round-robin pointers = 0.
  - Reset mid-operation discards every queued or in-flight packet; none are delivered afterwards.
- Input accept:
  - Channel c accepts when valid && net_ready_o[c]. net_ready_o[c] = !full[c], registered-state derived; a same-cycle pop does not raise ready.
  - If valid is high while full, the packet is not taken. The source must hold it; no drop occurs.
- Destination check at accept:
  - A destination of zero, or with more than one bit set, is not written to the FIFO.
  - route_err_o is set, and drop_count_o increments, saturating at all ones.
  - The packet still counts as accepted (ready was high).
- FIFO: a circular buffer per source with read/write pointers of log2(fifo_depth_p)+1 bits. Full when the MSBs differ and the low bits are equal; empty when the pointers are equal. Simultaneous push and pop when full is not possible, since ready is low.
- Output register d:
  - Loads when it is empty, or when net_ready_i[d] is high this cycle.
  - Otherwise it holds its contents stable until consumed; the valid bit is high while occupied.
- Arbitration per output d:
  - Candidates are the non-empty FIFO heads whose destination bit d is set.
  - Search order is ptr[d], ptr[d]+1, … modulo num_ch_p.
  - The winner is popped in the same cycle the output loads, and ptr[d] becomes winner+1 mod num_ch_p.
  - With no candidate, the output clears valid when consumed; the pointer is unchanged.
  - Each head targets one output, so there are no cross-output conflicts.
  - Loopback (source == destination) is legal.
- Timing:
  - Latency from accept to output valid is 2 cycles minimum.
  - Throughput is one packet per output per cycle. All outputs proceed in parallel.
  - Packets from the same source to the same destination stay in order.
- Barrier and exception:
  - barrier_o is registered each cycle as the AND over channels of barrier_flat_i, giving 1-cycle latency.
  - exception_src_o[c] is set when exception_i[c] is high and clears only on reset. exception_o = |exception_src_o.
- Payload passes through unmodified, including the destination field.

Test Plan:
- Reset then idle: all outputs 0, net_ready_o=4'b1111. Assert reset mid-traffic with 3 packets queued → all outputs 0 next cycle; no packets delivered after release.
- Single packet from ch0 with dest 4'b0100, payload 0x00AB_CDEF → ch2 output valid exactly 2 cycles after accept, payload identical; other outputs stay invalid.
- Contention: ch0, ch1 and ch3 all send to dest 4'b0001 every cycle with net_ready_i=all ones → ch0 output grants sources in order 0,1,3,0,1,3…, with no starvation over 30 cycles.
- Backpressure: net_ready_i[1]=0 while ch2 streams 6 packets to dest 4'b0010 → output held stable; ch2 accepts 4 FIFO entries plus 1 in the output register, then net_ready_o[2]=0. Release ready → all 6 delivered in order.
- Illegal destinations: send dest 4'b0000, then 4'b0110 → neither delivered; route_err_o=1; drop_count_o=2; net_ready_o unaffected.
- Status: barrier masks 0x3FF, 0x3F0, 0x3FF, 0x1F0 → barrier_o=0x1F0 one cycle later. Pulse exception_i[2] for 1 cycle → exception_o=1 and exception_src_o=4'b0100, held until reset.
